// File: rtl/l2_port_arbiter_pkg.sv
// Shared encodings for the L2 port arbiter: FSM states, requester ids and default fill timeout.
package l2_arb_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_e;

    localparam logic REQ_IF = 1'b0;
    localparam logic REQ_DM = 1'b1;

    localparam int STALL_MAX_DEFAULT = 64;

endpackage

// File: rtl/l2_port_arbiter_rr_pick2.sv
// Two-way round-robin pick: on contention rr_ptr wins, otherwise the single eligible requester wins.
module rr_pick2
    import l2_arb_pkg::*;
(
    input  logic [1:0] elig,
    input  logic       rr_ptr,
    output logic       gnt_valid,
    output logic       gnt_id
);

    assign gnt_valid = |elig;
    assign gnt_id    = (&elig) ? rr_ptr : elig[REQ_DM];

endmodule

// File: rtl/l2_port_arbiter.sv
// Arbitrates the single L2 port between instruction fetch (req 0) and data access (req 1),
// holding the grant through miss fills and aborting a fill that stalls too long.
module l2_port_arbiter
    import l2_arb_pkg::*;
#(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int STALL_MAX = STALL_MAX_DEFAULT,
    parameter int CNT_W     = 7
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0_valid,
    input  logic              req0_we,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_wdata,
    input  logic              req1_valid,
    input  logic              req1_we,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_wdata,
    output logic              done0,
    output logic              done1,
    output logic              err0,
    output logic              err1,
    output logic [DATA_W-1:0] rdata,
    output logic [ADDR_W-1:0] l2_addr,
    output logic [DATA_W-1:0] l2_wdata,
    output logic              l2_renable,
    output logic              l2_wenable,
    input  logic [DATA_W-1:0] l2_rdata,
    input  logic              l2_stall,
    output logic              busy,
    output state_e            dbg_state,
    output logic [CNT_W-1:0]  dbg_stall_cnt
);

    // Handshake: reqN_valid is a level that the requester holds, with its fields, until it sees
    // a one-cycle doneN or errN pulse; the valid still high during that pulse is not a new request.

    state_e             state;
    logic               grant;
    logic               rr_ptr;
    logic               lat_we;
    logic [CNT_W-1:0]   stall_cnt;
    logic [1:0]         elig;
    logic               gnt_valid;
    logic               gnt_id;

    assign elig = {req1_valid & ~done1 & ~err1, req0_valid & ~done0 & ~err0};

    rr_pick2 u_pick (
        .elig      (elig),
        .rr_ptr    (rr_ptr),
        .gnt_valid (gnt_valid),
        .gnt_id    (gnt_id)
    );

    assign dbg_state     = state;
    assign dbg_stall_cnt = stall_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            grant      <= REQ_IF;
            rr_ptr     <= REQ_IF;
            lat_we     <= 1'b0;
            stall_cnt  <= '0;
            done0      <= 1'b0;
            done1      <= 1'b0;
            err0       <= 1'b0;
            err1       <= 1'b0;
            busy       <= 1'b0;
            l2_renable <= 1'b0;
            l2_wenable <= 1'b0;
            l2_addr    <= '0;
            l2_wdata   <= '0;
            rdata      <= '0;
        end else begin
            done0 <= 1'b0;
            done1 <= 1'b0;
            err0  <= 1'b0;
            err1  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (gnt_valid) begin
                        grant      <= gnt_id;
                        rr_ptr     <= ~gnt_id;
                        stall_cnt  <= '0;
                        lat_we     <= (gnt_id == REQ_DM) ? req1_we : req0_we;
                        l2_addr    <= (gnt_id == REQ_DM) ? req1_addr : req0_addr;
                        l2_wdata   <= (gnt_id == REQ_DM) ? req1_wdata : req0_wdata;
                        l2_renable <= (gnt_id == REQ_DM) ? ~req1_we : ~req0_we;
                        l2_wenable <= (gnt_id == REQ_DM) ? req1_we : req0_we;
                        busy       <= 1'b1;
                        state      <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    // Writes complete in one cycle regardless of l2_stall.
                    if (lat_we || !l2_stall) begin
                        if (!lat_we) begin
                            rdata <= l2_rdata;
                        end
                        if (grant == REQ_DM) begin
                            done1 <= 1'b1;
                        end else begin
                            done0 <= 1'b1;
                        end
                        l2_renable <= 1'b0;
                        l2_wenable <= 1'b0;
                        busy       <= 1'b0;
                        state      <= ST_IDLE;
                    end else if (stall_cnt == CNT_W'(STALL_MAX - 1)) begin
                        if (grant == REQ_DM) begin
                            err1 <= 1'b1;
                        end else begin
                            err0 <= 1'b1;
                        end
                        l2_renable <= 1'b0;
                        l2_wenable <= 1'b0;
                        busy       <= 1'b0;
                        state      <= ST_IDLE;
                    end else begin
                        stall_cnt <= stall_cnt + 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_l2_port_arbiter.sv
// Bench for l2_port_arbiter: cycle-by-cycle vector table plus hand-written contention,
// timeout and asynchronous-reset sequences.
module tb_l2_port_arbiter;
    import l2_arb_pkg::*;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SM = 8;
    localparam int CW = 7;
    localparam logic H = 1'b1;
    localparam logic L = 1'b0;

    logic          clk;
    logic          rst;
    logic          req0_valid, req0_we, req1_valid, req1_we;
    logic [AW-1:0] req0_addr, req1_addr;
    logic [DW-1:0] req0_wdata, req1_wdata;
    logic          done0, done1, err0, err1, busy;
    logic [DW-1:0] rdata, l2_wdata, l2_rdata;
    logic [AW-1:0] l2_addr;
    logic          l2_renable, l2_wenable, l2_stall;
    state_e        dbg_state;
    logic [CW-1:0] dbg_stall_cnt;

    typedef struct packed {
        logic          d0, d1, e0, e1, busy, ren, wen;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [DW-1:0] rdata;
        logic [CW-1:0] cnt;
    } outs_t;

    typedef struct {
        logic          r0v, r0we;
        logic [AW-1:0] r0a;
        logic [DW-1:0] r0d;
        logic          r1v, r1we;
        logic [AW-1:0] r1a;
        logic [DW-1:0] r1d;
        logic [DW-1:0] l2rd;
        logic          stall;
        outs_t         exp;
    } vec_t;

    int errors = 0;
    int checks = 0;
    logic [AW-1:0] exp_q[$];
    vec_t vecs[$];

    l2_port_arbiter #(
        .ADDR_W(AW), .DATA_W(DW), .STALL_MAX(SM), .CNT_W(CW)
    ) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_we(req0_we), .req0_addr(req0_addr), .req0_wdata(req0_wdata),
        .req1_valid(req1_valid), .req1_we(req1_we), .req1_addr(req1_addr), .req1_wdata(req1_wdata),
        .done0(done0), .done1(done1), .err0(err0), .err1(err1), .rdata(rdata),
        .l2_addr(l2_addr), .l2_wdata(l2_wdata), .l2_renable(l2_renable), .l2_wenable(l2_wenable),
        .l2_rdata(l2_rdata), .l2_stall(l2_stall), .busy(busy),
        .dbg_state(dbg_state), .dbg_stall_cnt(dbg_stall_cnt)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic outs_t sample();
        return {done0, done1, err0, err1, busy, l2_renable, l2_wenable,
                l2_addr, l2_wdata, rdata, dbg_stall_cnt};
    endfunction

    function automatic outs_t mk_exp(logic d0, logic d1, logic e0, logic e1, logic b, logic ren,
                                     logic wen, logic [AW-1:0] a, logic [DW-1:0] wd,
                                     logic [DW-1:0] rd, logic [CW-1:0] c);
        return {d0, d1, e0, e1, b, ren, wen, a, wd, rd, c};
    endfunction

    function automatic vec_t mk_vec(logic r0v, logic r0we, logic [AW-1:0] r0a, logic [DW-1:0] r0d,
                                    logic r1v, logic r1we, logic [AW-1:0] r1a, logic [DW-1:0] r1d,
                                    logic [DW-1:0] l2rd, logic stall, outs_t e);
        vec_t v;
        v.r0v = r0v; v.r0we = r0we; v.r0a = r0a; v.r0d = r0d;
        v.r1v = r1v; v.r1we = r1we; v.r1a = r1a; v.r1d = r1d;
        v.l2rd = l2rd; v.stall = stall; v.exp = e;
        return v;
    endfunction

    // ---------------- scoreboard helpers ----------------
    task automatic check_outs(input string name, input outs_t exp);
        outs_t got;
        got = sample();
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    task automatic check_val(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic drive_idle();
        req0_valid = 1'b0; req0_we = 1'b0; req0_addr = '0; req0_wdata = '0;
        req1_valid = 1'b0; req1_we = 1'b0; req1_addr = '0; req1_wdata = '0;
        l2_rdata = '0; l2_stall = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive_idle();
        repeat (2) @(posedge clk);
        #1;
        check_outs("reset_state", '0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic apply_vec(input vec_t v);
        req0_valid = v.r0v; req0_we = v.r0we; req0_addr = v.r0a; req0_wdata = v.r0d;
        req1_valid = v.r1v; req1_we = v.r1we; req1_addr = v.r1a; req1_wdata = v.r1d;
        l2_rdata = v.l2rd; l2_stall = v.stall;
    endtask

    initial begin
        int n;
        logic saw_done0;
        logic prev_busy, prev_d0, prev_d1;
        logic ok;

        rst = 1'b1;
        drive_idle();

        // Read hit, stale-valid masking, write with ignored stall, read miss, late req0.
        vecs.push_back(mk_vec(H, L, 32'h40, 32'h0, L, L, 32'h0, 32'h0, 32'hDEAD_BEEF, L,
                              mk_exp(L, L, L, L, H, H, L, 32'h40, 32'h0, 32'h0, 7'd0)));
        vecs.push_back(mk_vec(H, L, 32'h40, 32'h0, L, L, 32'h0, 32'h0, 32'hDEAD_BEEF, L,
                              mk_exp(H, L, L, L, L, L, L, 32'h40, 32'h0, 32'hDEAD_BEEF, 7'd0)));
        vecs.push_back(mk_vec(H, L, 32'h40, 32'h0, L, L, 32'h0, 32'h0, 32'hDEAD_BEEF, L,
                              mk_exp(L, L, L, L, L, L, L, 32'h40, 32'h0, 32'hDEAD_BEEF, 7'd0)));
        vecs.push_back(mk_vec(L, L, 32'h40, 32'h0, L, L, 32'h0, 32'h0, 32'h0, L,
                              mk_exp(L, L, L, L, L, L, L, 32'h40, 32'h0, 32'hDEAD_BEEF, 7'd0)));
        vecs.push_back(mk_vec(L, L, 32'h0, 32'h0, H, H, 32'h20, 32'hA5A5_A5A5, 32'h0, H,
                              mk_exp(L, L, L, L, H, L, H, 32'h20, 32'hA5A5_A5A5, 32'hDEAD_BEEF, 7'd0)));
        vecs.push_back(mk_vec(L, L, 32'h0, 32'h0, H, H, 32'h20, 32'hA5A5_A5A5, 32'h0, H,
                              mk_exp(L, H, L, L, L, L, L, 32'h20, 32'hA5A5_A5A5, 32'hDEAD_BEEF, 7'd0)));
        vecs.push_back(mk_vec(L, L, 32'h0, 32'h0, L, L, 32'h0, 32'h0, 32'h0, L,
                              mk_exp(L, L, L, L, L, L, L, 32'h20, 32'hA5A5_A5A5, 32'hDEAD_BEEF, 7'd0)));
        vecs.push_back(mk_vec(L, L, 32'h0, 32'h0, H, L, 32'h100, 32'h0, 32'h0, H,
                              mk_exp(L, L, L, L, H, H, L, 32'h100, 32'h0, 32'hDEAD_BEEF, 7'd0)));
        vecs.push_back(mk_vec(L, L, 32'h0, 32'h0, H, L, 32'h100, 32'h0, 32'h0, H,
                              mk_exp(L, L, L, L, H, H, L, 32'h100, 32'h0, 32'hDEAD_BEEF, 7'd1)));
        vecs.push_back(mk_vec(L, L, 32'h0, 32'h0, H, H, 32'h200, 32'h77, 32'h0, H,
                              mk_exp(L, L, L, L, H, H, L, 32'h100, 32'h0, 32'hDEAD_BEEF, 7'd2)));
        vecs.push_back(mk_vec(H, L, 32'h300, 32'h0, H, L, 32'h100, 32'h0, 32'h0, H,
                              mk_exp(L, L, L, L, H, H, L, 32'h100, 32'h0, 32'hDEAD_BEEF, 7'd3)));
        vecs.push_back(mk_vec(H, L, 32'h300, 32'h0, H, L, 32'h100, 32'h0, 32'h0, H,
                              mk_exp(L, L, L, L, H, H, L, 32'h100, 32'h0, 32'hDEAD_BEEF, 7'd4)));
        vecs.push_back(mk_vec(H, L, 32'h300, 32'h0, H, L, 32'h100, 32'h0, 32'h0, H,
                              mk_exp(L, L, L, L, H, H, L, 32'h100, 32'h0, 32'hDEAD_BEEF, 7'd5)));
        vecs.push_back(mk_vec(H, L, 32'h300, 32'h0, H, L, 32'h100, 32'h0, 32'h1234_5678, L,
                              mk_exp(L, H, L, L, L, L, L, 32'h100, 32'h0, 32'h1234_5678, 7'd5)));
        vecs.push_back(mk_vec(H, L, 32'h300, 32'h0, L, L, 32'h0, 32'h0, 32'h0, L,
                              mk_exp(L, L, L, L, H, H, L, 32'h300, 32'h0, 32'h1234_5678, 7'd0)));
        vecs.push_back(mk_vec(H, L, 32'h300, 32'h0, L, L, 32'h0, 32'h0, 32'hCAFE_F00D, L,
                              mk_exp(H, L, L, L, L, L, L, 32'h300, 32'h0, 32'hCAFE_F00D, 7'd0)));
        vecs.push_back(mk_vec(L, L, 32'h0, 32'h0, L, L, 32'h0, 32'h0, 32'h0, L,
                              mk_exp(L, L, L, L, L, L, L, 32'h300, 32'h0, 32'hCAFE_F00D, 7'd0)));

        do_reset();
        for (int i = 0; i < vecs.size(); i++) begin
            apply_vec(vecs[i]);
            step();
            check_outs($sformatf("vec%0d", i), vecs[i].exp);
        end

        // Timeout: stall held high, err0 expected STALL_MAX edges after the grant.
        drive_idle();
        req0_valid = 1'b1; req0_addr = 32'h400; l2_stall = 1'b1;
        step();
        check_val("timeout_grant", {30'd0, busy, l2_renable}, 32'd3);
        n = 0;
        saw_done0 = 1'b0;
        while (n < 20 && !err0) begin
            step();
            n++;
            if (done0) saw_done0 = 1'b1;
        end
        check_val("timeout_cycles", n, SM);
        check_val("timeout_no_done", {31'd0, saw_done0}, 32'd0);
        check_val("timeout_idle", {31'd0, busy}, 32'd0);
        check_val("timeout_rdata", rdata, 32'hCAFE_F00D);
        req0_valid = 1'b0;
        step();
        check_val("timeout_err_pulse", {31'd0, err0}, 32'd0);

        // Reset during the third stall cycle of a miss, then req1 alone is granted.
        drive_idle();
        req0_valid = 1'b1; req0_addr = 32'h500; l2_stall = 1'b1;
        repeat (3) step();
        check_val("mid_cnt", {25'd0, dbg_stall_cnt}, 32'd2);
        #2;
        rst = 1'b1;
        #1;
        check_outs("async_reset", '0);
        check_val("async_state", {31'd0, dbg_state}, {31'd0, ST_IDLE});
        req0_valid = 1'b0;
        req1_valid = 1'b1; req1_addr = 32'h600; l2_stall = 1'b0; l2_rdata = 32'h66;
        @(negedge clk);
        rst = 1'b0;
        step();
        check_outs("post_reset_req1", mk_exp(L, L, L, L, H, H, L, 32'h600, 32'h0, 32'h0, 7'd0));
        step();
        check_outs("post_reset_done1", mk_exp(L, H, L, L, L, L, L, 32'h600, 32'h0, 32'h66, 7'd0));

        // Contention from reset: both continuously valid, grants must alternate 0,1,0,1,0.
        do_reset();
        req0_valid = 1'b1; req0_addr = 32'h1000;
        req1_valid = 1'b1; req1_addr = 32'h2000;
        l2_rdata = 32'h55; l2_stall = 1'b0;
        exp_q.push_back(32'h1000); exp_q.push_back(32'h2000); exp_q.push_back(32'h1000);
        exp_q.push_back(32'h2000); exp_q.push_back(32'h1000);
        prev_busy = 1'b0; prev_d0 = 1'b0; prev_d1 = 1'b0;
        for (int c = 0; c < 10; c++) begin
            step();
            if (busy && !prev_busy) begin
                if (exp_q.size() == 0) begin
                    check_val("rr_extra_grant", l2_addr, 32'h0);
                end else begin
                    check_val($sformatf("rr_grant_c%0d", c), l2_addr, exp_q.pop_front());
                end
            end
            ok = !(done0 && done1) && !(done0 && prev_d0) && !(done1 && prev_d1);
            check_val($sformatf("rr_done_pulse_c%0d", c), {31'd0, ok}, 32'd1);
            prev_busy = busy; prev_d0 = done0; prev_d1 = done1;
        end
        check_val("rr_grants_left", exp_q.size(), 32'd0);

        // Reset with both pending: rr_ptr is back at req 0.
        do_reset();
        req0_valid = 1'b1; req0_addr = 32'h700;
        req1_valid = 1'b1; req1_addr = 32'h800;
        step();
        check_val("reset_rr_ptr_grant", l2_addr, 32'h700);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/l2_port_arbiter.md
Name: l2_port_arbiter

Overview:
- Shares the single L2 cache port between two requesters: req 0 (instruction fetch) and req 1 (data load/store).
- Sits between the core's L1-side request interfaces and the L2 cache. Drives the L2 address, write data, and read/write enables, and watches the L2 stall/hit outputs.
- Grants round-robin, holds the grant across multi-cycle L2 miss fills, returns read data with a one-cycle done pulse, and aborts with an error if a fill hangs.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data word width.
- STALL_MAX, 64, max consecutive BUSY cycles with l2_stall high before abort; must be ≥ 8.
- CNT_W, 7, stall counter width; must satisfy 2^CNT_W > STALL_MAX.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- req0_valid  in  1  req 0 request; level, held until done0 or err0.
- req0_we  in  1  req 0: 1 = write, 0 = read.
- req0_addr  in  ADDR_W  req 0 byte address (word aligned).
- req0_wdata  in  DATA_W  req 0 write data.
- req1_valid, req1_we, req1_addr, req1_wdata  in  1/1/ADDR_W/DATA_W  same fields for req 1.
- done0, done1  out  1  one-cycle completion pulse per requester.
- err0, err1  out  1  one-cycle abort pulse (stall timeout).
- rdata  out  DATA_W  read result; valid in the done cycle, held until the next completion.
- l2_addr  out  ADDR_W  to L2 addr.
- l2_wdata  out  DATA_W  to L2 wdata.
- l2_renable  out  1  to L2 renable.
- l2_wenable  out  1  to L2 wenable.
- l2_rdata  in  DATA_W  from L2 rdata; combinational on a hit.
- l2_stall  in  1  from L2; high while a read miss fills.
- busy  out  1  high in BUSY state.

Behaviour:
- States: IDLE, BUSY. Registers: state, grant (1 bit), rr_ptr (1 bit, the requester with priority), latched addr/we/wdata, stall_cnt (CNT_W bits).
- Reset (async): state = IDLE; rr_ptr = 0; grant = 0; stall_cnt = 0. Outputs done0/1, err0/1, busy, l2_renable, l2_wenable = 0; l2_addr, l2_wdata, rdata = 0.
- A reset asserted mid-operation drops the transaction silently; no done or err is generated.
- IDLE arbitration, per requester:
  - eligible = reqN_valid & ~doneN & ~errN. This masks the stale valid that a requester still holds in the cycle of its own pulse.
  - Both eligible: grant = rr_ptr.
  - One eligible: grant goes to it.
  - On a grant edge: latch addr/we/wdata from the winner; rr_ptr <= ~grant; stall_cnt <= 0; state <= BUSY.
  - Neither eligible: stay in IDLE; rr_ptr unchanged.
- BUSY outputs, all driven from registers:
  - l2_addr = latched addr; l2_wdata = latched wdata.
  - l2_renable = ~we; l2_wenable = we.
  - busy = 1.
  - In IDLE all L2 enables are 0; l2_addr and l2_wdata hold their last values.
- BUSY, write: exactly one BUSY cycle. At the next edge: done[grant] <= 1; state <= IDLE. l2_stall is ignored for writes.
- BUSY, read:
  - At each edge with l2_stall = 1: stall_cnt++.
  - At the first edge with l2_stall = 0: rdata <= l2_rdata; done[grant] <= 1; state <= IDLE.
  - If stall_cnt == STALL_MAX - 1 and l2_stall = 1 at an edge: err[grant] <= 1; state <= IDLE; rdata unchanged.
- Latency, from the edge that grants:
  - Read hit: done at edge +1, i.e. 2 cycles from request to done.
  - Read miss: edge +1+F, where F is the number of L2 fill cycles (5 for the current L2).
  - Write: edge +1.
- Throughput and changes:
  - Minimum of one IDLE cycle between transactions, so there is no back-to-back grant.
  - Changes to req fields after the grant are ignored until done/err.
- done and err are mutually exclusive, never both high in the same cycle, and never asserted for both requesters at once.
- Once granted, a request is never preempted.
- Fairness: with both requesters continuously valid, grants alternate 0, 1, 0, 1 …

Decomposition:
- Package l2_arb_pkg holds:
  - state encoding: ST_IDLE = 1'b0, ST_BUSY = 1'b1;
  - requester ids: REQ_IF = 1'b0, REQ_DM = 1'b1;
  - default STALL_MAX.
- Sub-module rr_pick2 (combinational): inputs elig[1:0] and rr_ptr; outputs gnt_valid and gnt_id. Instantiated once.

Test Plan:
- Reset then single read hit: req0 read addr 0x0000_0040; L2 returns 0xDEAD_BEEF with stall = 0 → l2_renable high 1 cycle, done0 at cycle 2, rdata = 0xDEAD_BEEF, done1/err0 never high.
- Read miss: req1 read 0x100; l2_stall high 5 cycles, then l2_rdata = 0x1234_5678 → l2_renable held 6 cycles, done1 pulses once, rdata = 0x1234_5678, stall_cnt reaches 5, no err.
- Contention: req0 and req1 both valid from reset, each re-requesting one cycle after its done, hit reads → grant order 0, 1, 0, 1; each done pulse is exactly 1 cycle; the requester whose done is high is never re-granted in that cycle.
- Write: req1 write addr 0x20, wdata 0xA5A5_A5A5 while req0 is idle → l2_wenable = 1 for exactly 1 cycle with l2_addr = 0x20, l2_wdata = 0xA5A5_A5A5; done1 on the next cycle; l2_stall = 1 is ignored.
- Timeout: req0 read with l2_stall held high, STALL_MAX = 8 → err0 pulses after 8 BUSY cycles, no done0, state returns to IDLE, rdata unchanged.
- Reset mid-miss: assert rst during the 3rd stall cycle → all outputs 0 immediately (async), no done/err; after release, a pending req1 is granted first only if req0 is absent (rr_ptr = 0).
